fetch_issue_unit: RTL and testbench

- Instruction-side counterpart of the control decoder: owns the PC and fetches instruction words from instruction memory over a request/response handshake.
- Presents one instruction at a time (Instr, Opcode, Func) to the decoder and datapath.
- On acknowledge, consumes the decoder's PCSrc/Jump/JR resolution to select the next PC.
- Multicycle front end: exactly one instruction in flight.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/next_pc_sel.sv | 37 +++
 rtl/fetch_issue_unit.sv | 113 +++++++++++
 tb/tb_fetch_issue_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-state encoding and MIPS opcode/function constants.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ISSUE = 2'd3
  } fetch_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FUNC_JR  = 6'h08;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - next-PC mux: JR over Jump over PCSrc over sequential.
module next_pc_sel #(
  parameter int AW = 32
) (
  input  logic [AW-1:0] pc,
  input  logic [31:0]   instr,
  input  logic [31:0]   rs_data,
  input  logic          pc_src,
  input  logic          jump,
  input  logic          jr,
  output logic [AW-1:0] next_pc,
  output logic          misaligned
);

  logic [AW-1:0] pc_plus4;
  logic [AW-1:0] branch_tgt;
  logic [AW-1:0] jump_tgt;
  logic          unused_opcode_bits;

  assign pc_plus4   = pc + AW'(4);
  assign branch_tgt = pc_plus4 + {{(AW-18){instr[15]}}, instr[15:0], 2'b00};
  assign jump_tgt   = {pc_plus4[AW-1:28], instr[25:0], 2'b00};
  assign misaligned = |rs_data[1:0];
  assign unused_opcode_bits = ^instr[31:26];

  always_comb begin
    next_pc = pc_plus4;
    if (jr) begin
      next_pc = {rs_data[AW-1:2], 2'b00};
    end else if (jump) begin
      next_pc = jump_tgt;
    end else if (pc_src) begin
      next_pc = branch_tgt;
    end
  end

endmodule

// File: rtl/fetch_issue_unit.sv
// rtl/fetch_issue_unit.sv - multicycle fetch front end: one instruction in flight,
// PC update on decoder acknowledge.
module fetch_issue_unit #(
  parameter int                 IMEM_AW  = 32,
  parameter logic [IMEM_AW-1:0] RESET_PC = mips_pkg::DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  output logic               instr_valid,
  output logic [31:0]        Instr,
  output logic [5:0]         Opcode,
  output logic [5:0]         Func,
  output logic [IMEM_AW-1:0] PC,
  output logic [IMEM_AW-1:0] PCPlus4,
  input  logic               instr_ack,
  input  logic               PCSrc,
  input  logic               Jump,
  input  logic               JR,
  input  logic [31:0]        RsData,
  output logic               align_err,
  output logic [31:0]        retired
);
  import mips_pkg::*;

  fetch_state_e       state_q, state_d;
  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        retired_q, retired_d;
  logic               imem_req_q, imem_req_d;
  logic               instr_valid_q, instr_valid_d;
  logic               align_err_q, align_err_d;
  logic [IMEM_AW-1:0] next_pc;
  logic               misaligned;

  next_pc_sel #(.AW(IMEM_AW)) u_next_pc_sel (
    .pc         (pc_q),
    .instr      (instr_q),
    .rs_data    (RsData),
    .pc_src     (PCSrc),
    .jump       (Jump),
    .jr         (JR),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    retired_d   = retired_q;
    align_err_d = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (imem_ready) state_d = ST_WAIT;
      // rvalid is only honoured here, so stale or early responses are dropped
      ST_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (instr_ack) begin
          pc_d        = next_pc;
          retired_d   = retired_q + 32'd1;
          align_err_d = JR & misaligned;
          state_d     = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // outputs are registered, so they are derived from the state being entered
    imem_req_d    = (state_d == ST_FETCH);
    instr_valid_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      retired_q     <= 32'h0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      align_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      retired_q     <= retired_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      align_err_q   <= align_err_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign Instr       = instr_q;
  assign Opcode      = instr_q[31:26];
  assign Func        = instr_q[5:0];
  assign PC          = pc_q;
  assign PCPlus4     = pc_q + IMEM_AW'(4);
  assign align_err   = align_err_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_issue_unit.sv
// tb/tb_fetch_issue_unit.sv - directed and randomized bench for fetch_issue_unit
// against an arithmetic next-PC model.
module tb_fetch_issue_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] Instr;
  logic [5:0]  Opcode;
  logic [5:0]  Func;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        instr_ack;
  logic        PCSrc;
  logic        Jump;
  logic        JR;
  logic [31:0] RsData;
  logic        align_err;
  logic [31:0] retired;

  fetch_issue_unit #(.IMEM_AW(32), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .Instr       (Instr),
    .Opcode      (Opcode),
    .Func        (Func),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .instr_ack   (instr_ack),
    .PCSrc       (PCSrc),
    .Jump        (Jump),
    .JR          (JR),
    .RsData      (RsData),
    .align_err   (align_err),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;
  logic [31:0] cur_instr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                             input bit pcsrc, input bit jump, input bit jr,
                                             input logic [31:0] rs);
    logic [31:0]        seq;
    logic signed [31:0] off;
    seq = pc + 32'd4;
    if (jr) return rs - (rs % 32'd4);
    if (jump) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
    if (pcsrc) begin
      off = $signed(ins[15:0]);
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  task automatic do_fetch(input logic [31:0] word, input int ready_lag, input int resp_lag,
                          input bit stray);
    chk("fetch_req", {31'b0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    for (int i = 0; i < ready_lag; i++) begin
      imem_ready  = 1'b0;
      imem_rvalid = stray;
      imem_rdata  = $urandom;
      step();
      chk("fetch_hold_req", {31'b0, imem_req}, 32'd1);
      chk("fetch_hold_addr", imem_addr, exp_pc);
      chk("fetch_hold_valid", {31'b0, instr_valid}, 32'd0);
    end
    imem_ready  = 1'b1;
    imem_rvalid = stray;
    step();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    chk("wait_req", {31'b0, imem_req}, 32'd0);
    chk("wait_valid", {31'b0, instr_valid}, 32'd0);
    for (int i = 0; i < resp_lag; i++) begin
      step();
      chk("wait_hold_valid", {31'b0, instr_valid}, 32'd0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    cur_instr   = word;
    chk("issue_valid", {31'b0, instr_valid}, 32'd1);
    chk("issue_instr", Instr, word);
    chk("issue_opcode", {26'b0, Opcode}, word >> 26);
    chk("issue_func", {26'b0, Func}, word & 32'h3F);
    chk("issue_pc", PC, exp_pc);
    chk("issue_pcplus4", PCPlus4, exp_pc + 32'd4);
  endtask

  task automatic do_ack(input bit pcsrc, input bit jump, input bit jr, input logic [31:0] rs,
                        input int hold);
    logic [31:0] nxt;
    for (int i = 0; i < hold; i++) begin
      instr_ack = 1'b0;
      PCSrc     = 1'($urandom);
      Jump      = 1'($urandom);
      JR        = 1'($urandom);
      RsData    = $urandom;
      step();
      chk("hold_valid", {31'b0, instr_valid}, 32'd1);
      chk("hold_pc", PC, exp_pc);
      chk("hold_align", {31'b0, align_err}, 32'd0);
    end
    PCSrc     = pcsrc;
    Jump      = jump;
    JR        = jr;
    RsData    = rs;
    instr_ack = 1'b1;
    step();
    instr_ack = 1'b0;
    PCSrc     = 1'($urandom);
    Jump      = 1'($urandom);
    JR        = 1'($urandom);
    RsData    = $urandom;
    nxt     = model_next(exp_pc, cur_instr, pcsrc, jump, jr, rs);
    exp_pc  = nxt;
    exp_ret = exp_ret + 32'd1;
    chk("ack_align", {31'b0, align_err}, (jr && (rs % 32'd4 != 0)) ? 32'd1 : 32'd0);
    chk("ack_retired", retired, exp_ret);
    chk("ack_valid", {31'b0, instr_valid}, 32'd0);
    chk("ack_req", {31'b0, imem_req}, 32'd1);
    chk("ack_next_addr", imem_addr, exp_pc);
    step();
    chk("align_pulse_end", {31'b0, align_err}, 32'd0);
    chk("refetch_addr", imem_addr, exp_pc);
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    instr_ack   = 1'b0;
    PCSrc       = 1'b0;
    Jump        = 1'b0;
    JR          = 1'b0;
    RsData      = 32'h0;
    exp_pc      = RST_PC;
    exp_ret     = 32'h0;
    cur_instr   = 32'h0;

    step();
    step();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_align", {31'b0, align_err}, 32'd0);
    chk("rst_pc", PC, RST_PC);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_retired", retired, 32'h0);
    rst_n = 1'b1;
    step();

    // ADDI at 0, then sequential to 4 and 8
    do_fetch(32'h2008_0005, 0, 0, 1'b0);
    chk("addi_opcode", {26'b0, Opcode}, 32'h08);
    do_ack(1'b0, 1'b0, 1'b0, 32'h0, 0);
    chk("after_addi_addr", imem_addr, 32'h4);
    do_fetch(32'h2008_0005, 1, 1, 1'b0);
    do_ack(1'b0, 1'b0, 1'b0, 32'h0, 1);

    // J at 8 -> 0x100
    do_fetch(32'h0800_0040, 0, 2, 1'b0);
    do_ack(1'b0, 1'b1, 1'b0, 32'h0, 0);
    chk("j_target", imem_addr, 32'h100);

    // JR back to 8, then JAL at 8 checks the link value
    do_fetch(32'h0100_0008, 0, 0, 1'b0);
    do_ack(1'b0, 1'b0, 1'b1, 32'h8, 0);
    do_fetch(32'h0C00_0040, 0, 0, 1'b0);
    chk("jal_link", PCPlus4, 32'hC);
    do_ack(1'b0, 1'b1, 1'b0, 32'h0, 0);

    // BEQ at 0x10 taken (offset -1) and not taken
    do_fetch(32'h0100_0008, 0, 0, 1'b0);
    do_ack(1'b0, 1'b0, 1'b1, 32'h10, 0);
    do_fetch(32'h1000_FFFF, 0, 0, 1'b0);
    do_ack(1'b1, 1'b0, 1'b0, 32'h0, 0);
    chk("beq_taken", imem_addr, 32'h10);
    do_fetch(32'h1000_FFFF, 0, 0, 1'b0);
    do_ack(1'b0, 1'b0, 1'b0, 32'h0, 0);
    chk("beq_not_taken", imem_addr, 32'h14);

    // JR wins over Jump and PCSrc; misaligned target
    do_fetch(32'h0100_0008, 0, 0, 1'b0);
    do_ack(1'b1, 1'b1, 1'b1, 32'h203, 0);
    chk("jr_priority", imem_addr, 32'h200);

    // slow memory with stray responses during FETCH
    do_fetch(32'h2008_0005, 5, 0, 1'b1);
    do_ack(1'b0, 1'b0, 1'b0, 32'h0, 0);

    // PC wrap from the top of the address space
    do_fetch(32'h0100_0008, 0, 0, 1'b0);
    do_ack(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 0);
    do_fetch(32'h2008_0005, 0, 0, 1'b0);
    do_ack(1'b0, 1'b0, 1'b0, 32'h0, 0);
    chk("pc_wrap", imem_addr, 32'h0);

    for (int n = 0; n < 40; n++) begin
      do_fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      do_ack(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), $urandom,
             $urandom_range(0, 2));
    end

    // reset while waiting for a response; the late response must be dropped
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    chk("midwait_req", {31'b0, imem_req}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", PC, RST_PC);
    chk("async_rst_retired", retired, 32'h0);
    step();
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    chk("postrst_valid", {31'b0, instr_valid}, 32'd0);
    chk("postrst_req", {31'b0, imem_req}, 32'd1);
    chk("postrst_addr", imem_addr, RST_PC);
    chk("postrst_instr", Instr, 32'h0);
    chk("postrst_retired", retired, 32'h0);
    step();
    imem_rvalid = 1'b0;
    chk("postrst_stale_valid", {31'b0, instr_valid}, 32'd0);
    exp_pc  = RST_PC;
    exp_ret = 32'h0;
    do_fetch(32'h2008_0005, 0, 0, 1'b0);
    do_ack(1'b0, 1'b0, 1'b0, 32'h0, 0);
    chk("postrst_retire_one", retired, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
